scan_word: RTL and testbench
============================

# scan_word

Receive-side assembler for the serial debug unit. Accepts a stream of bytes from the UART receiver over a valid/ready handshake and packs them into a single byte or a 32-bit word, least-significant byte first, for the debug command controller. A four-phase req/ack handshake connects it to the controller. This is the receive-side mirror of the byte/word print path, and uses the same byte order, so a word printed and echoed back reassembles unchanged.

## Interface
- TIMEOUT, 0, maximum idle gap in cycles between bytes of a partially received word; 0 disables the timeout.
- clk  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- req_rx  in  1  controller requests one item; held high until ack_rx is seen.
- type_rx  in  1  item size: 0 = byte, 1 = word (4 bytes); sampled on the req_rx rising cycle.
- vld_rx  in  1  UART receiver has a byte on d_rx.
- d_rx  in  8  received byte.
- rdy_rx  out  1  block can accept a byte this cycle.
- din_rx  out  32  assembled item; a byte is zero-extended.
- ack_rx  out  1  din_rx is valid; held until req_rx falls.
- err_rx  out  1  one-cycle pulse when a partial word is discarded on timeout.

## Operation
- States:
  - IDLE: rdy_rx=0, ack_rx=0.
  - RECV: rdy_rx=1.
  - DONE: rdy_rx=0, ack_rx=1.
- IDLE -> RECV when req_rx=1:
  - latch type_rx
  - clear byte count cnt (2 bits) and the gap counter
  - clear din_rx to 0
- Byte accept happens when vld_rx & rdy_rx on a clock edge:
  - d_rx is written to din_rx lane cnt: lane 0 = [7:0], lane 3 = [31:24].
  - cnt increments and the gap counter clears.
- Completion:
  - Byte mode: the first accepted byte moves RECV -> DONE.
  - Word mode: the fourth accepted byte (cnt==3) moves RECV -> DONE.
- DONE -> IDLE when req_rx=0. din_rx holds its value until the next IDLE -> RECV.
- Request withdrawn: if req_rx=0 in RECV, the block returns to IDLE with no ack. A byte offered in that same cycle is not accepted, because the state check takes priority.
- Timeout (TIMEOUT>0, word mode, cnt>0 only):
  - The gap counter counts cycles with no accept.
  - When it reaches TIMEOUT, the block clears cnt, din_rx and the gap counter, pulses err_rx for 1 cycle, and stays in RECV.
  - If an accept and the timeout fall in the same cycle, the accept wins and no error is raised.
- Bytes arriving in IDLE or DONE are never consumed, since rdy_rx=0. The UART receiver is responsible for holding or dropping them.
- Reset (rstn=0 at a clock edge), including mid-word:
  - state IDLE
  - rdy_rx=0, ack_rx=0, err_rx=0
  - din_rx=0, cnt=0, gap counter=0

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from input to output.
- req_rx rising at edge N: rdy_rx is high from cycle N+1.
- Throughput is at most one byte per cycle while in RECV. Back-to-back vld_rx delivers a word in 4 cycles.
- Final byte accepted at edge M: ack_rx=1 and din_rx final from cycle M+1, and rdy_rx=0 in the same cycle.
- req_rx falls at edge K while in DONE: ack_rx=0 from cycle K+1. A new request can be sampled at edge K+1 at the earliest.
- Timeout example: the last accept is at edge A and no further bytes arrive. The gap counter reaches TIMEOUT at edge A+TIMEOUT, and err_rx is high for cycle A+TIMEOUT+1.

## Test plan
- Byte read:
  - Stimulus: req_rx=1, type_rx=0, then vld_rx with d_rx=8'hA5.
  - Required: din_rx=32'h000000A5, ack_rx=1 one cycle after the accept, rdy_rx=0; ack_rx drops one cycle after req_rx falls.
- Word read, back-to-back:
  - Stimulus: type_rx=1, bytes 8'h78, 8'h56, 8'h34, 8'h12 on consecutive cycles.
  - Required: din_rx=32'h12345678, ack_rx one cycle after the fourth byte; exactly 4 accepts.
- Word read with gaps and stalls:
  - Stimulus: vld_rx with 0–5 idle cycles between bytes, TIMEOUT=16.
  - Required: same assembled value, err_rx never asserted.
- Timeout:
  - Stimulus: TIMEOUT=8; send 2 bytes, go silent for 8 cycles, then send 8'hEF, 8'hBE, 8'hAD, 8'hDE.
  - Required: err_rx pulses once; din_rx=32'hDEADBEEF.
- Abort and reset:
  - Stimulus: drop req_rx after 2 word bytes; separately, assert rstn=0 after 3 bytes.
  - Required: return to IDLE with no ack. After reset, all outputs are 0, and the next full word assembles correctly.
- Ignored input:
  - Stimulus: vld_rx=1 while idle or while ack_rx is high.
  - Required: rdy_rx=0, din_rx unchanged.

Source files
------------

// File: rtl/scan_word.sv
// Packs UART bytes LSB-first into a byte or 32-bit word for the debug controller (req/ack out).
// Latency: ack one cycle after the final accepted byte; rdy_rx is high only while collecting, one byte per cycle max.
module scan_word #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_rx,
    input  logic        type_rx,
    input  logic        vld_rx,
    input  logic [7:0]  d_rx,
    output logic        rdy_rx,
    output logic [31:0] din_rx,
    output logic        ack_rx,
    output logic        err_rx
);

    localparam bit          TO_EN      = (TIMEOUT > 0);
    localparam int unsigned GW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          word_q, word_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   din_q, din_d;
    logic          err_q, err_d;

    logic          last_byte;
    logic          gap_active;
    logic          gap_expired;

    assign last_byte   = !word_q || (cnt_q == 2'd3);
    assign gap_active  = TO_EN && word_q && (cnt_q != 2'd0);
    // Expiry is detected on the edge where the idle count would reach TIMEOUT.
    assign gap_expired = gap_active && (gap_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        din_d   = din_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_rx) begin
                    state_d = ST_RECV;
                    word_d  = type_rx;
                    cnt_d   = 2'd0;
                    gap_d   = '0;
                    din_d   = 32'd0;
                end
            end

            ST_RECV: begin
                if (!req_rx) begin
                    state_d = ST_IDLE;
                end else if (vld_rx) begin
                    din_d[{cnt_q, 3'b000} +: 8] = d_rx;
                    cnt_d = cnt_q + 2'd1;
                    gap_d = '0;
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end
                end else if (gap_expired) begin
                    cnt_d = 2'd0;
                    gap_d = '0;
                    din_d = 32'd0;
                    err_d = 1'b1;
                end else if (gap_active) begin
                    gap_d = gap_q + GW'(1);
                end
            end

            ST_DONE: begin
                if (!req_rx) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            word_q  <= 1'b0;
            cnt_q   <= 2'd0;
            gap_q   <= '0;
            din_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    assign rdy_rx = (state_q == ST_RECV);
    assign ack_rx = (state_q == ST_DONE);
    assign din_rx = din_q;
    assign err_rx = err_q;

endmodule

// File: tb/tb_scan_word.sv
// Bench for scan_word: three instances (TIMEOUT 8/16/0) share stimulus; directed table, corner sequences, random vs model.
module tb_scan_word;

    localparam int N = 3;

    logic clk;
    logic rstn, req, typ, vld;
    logic [7:0] d;
    logic        rdy [N];
    logic        ack [N];
    logic        err [N];
    logic [31:0] din [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scan_word #(.TIMEOUT(8)) dut_a (
        .clk(clk), .rstn(rstn), .req_rx(req), .type_rx(typ), .vld_rx(vld), .d_rx(d),
        .rdy_rx(rdy[0]), .din_rx(din[0]), .ack_rx(ack[0]), .err_rx(err[0]));
    scan_word #(.TIMEOUT(16)) dut_b (
        .clk(clk), .rstn(rstn), .req_rx(req), .type_rx(typ), .vld_rx(vld), .d_rx(d),
        .rdy_rx(rdy[1]), .din_rx(din[1]), .ack_rx(ack[1]), .err_rx(err[1]));
    scan_word #(.TIMEOUT(0)) dut_c (
        .clk(clk), .rstn(rstn), .req_rx(req), .type_rx(typ), .vld_rx(vld), .d_rx(d),
        .rdy_rx(rdy[2]), .din_rx(din[2]), .ack_rx(ack[2]), .err_rx(err[2]));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 delivered; bytes kept in arrival order.
    int         m_to   [N];
    int         m_mode [N];
    logic       m_word [N];
    int         m_n    [N];
    int         m_gap  [N];
    logic       m_err  [N];
    logic [7:0] m_b    [N][4];

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            m_err[k] = 1'b0;
            if (!rstn) begin
                m_mode[k] = 0;
                m_n[k]    = 0;
                m_gap[k]  = 0;
            end else if (m_mode[k] == 0) begin
                if (req) begin
                    m_mode[k] = 1;
                    m_word[k] = typ;
                    m_n[k]    = 0;
                    m_gap[k]  = 0;
                end
            end else if (m_mode[k] == 1) begin
                if (!req) begin
                    m_mode[k] = 0;
                end else if (vld) begin
                    m_b[k][m_n[k]] = d;
                    m_n[k]   = m_n[k] + 1;
                    m_gap[k] = 0;
                    if (!m_word[k] || m_n[k] == 4) m_mode[k] = 2;
                end else if (m_to[k] > 0 && m_word[k] && m_n[k] > 0) begin
                    m_gap[k] = m_gap[k] + 1;
                    if (m_gap[k] == m_to[k]) begin
                        m_n[k]   = 0;
                        m_gap[k] = 0;
                        m_err[k] = 1'b1;
                    end
                end
            end else if (!req) begin
                m_mode[k] = 0;
            end
        end
    endtask

    function automatic logic [31:0] m_din(input int k);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < m_n[k]; i++) r = r | (32'(m_b[k][i]) << (8 * i));
        return r;
    endfunction

    function automatic logic [34:0] m_obs(input int k);
        return {m_mode[k] == 1, m_mode[k] == 2, m_err[k], m_din(k)};
    endfunction

    function automatic logic [34:0] obs(input int k);
        return {rdy[k], ack[k], err[k], din[k]};
    endfunction

    function automatic logic [34:0] ex(input logic r, input logic a, input logic e, input logic [31:0] dn);
        return {r, a, e, dn};
    endfunction

    task automatic check(input string name, input int k, input logic [34:0] act, input logic [34:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got rdy=%b ack=%b err=%b din=%h, expected rdy=%b ack=%b err=%b din=%h",
                     name, k, act[34], act[33], act[32], act[31:0], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic cyc(input logic r, input logic q, input logic t, input logic v, input logic [7:0] dd);
        rstn = r; req = q; typ = t; vld = v; d = dd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       rstn, req, typ, vld;
        logic [7:0] d;
        logic       e_rdy, e_ack;
        logic [31:0] e_din;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic q, input logic t, input logic v, input logic [7:0] dd,
                       input logic er, input logic ea, input logic [31:0] ed);
        vec_t x;
        x.rstn = r; x.req = q; x.typ = t; x.vld = v; x.d = dd;
        x.e_rdy = er; x.e_ack = ea; x.e_din = ed;
        tbl.push_back(x);
    endtask

    initial begin
        logic [7:0]  wb [4];
        int          gaps [4];
        logic [31:0] acc;
        int          win;
        int          pv;

        m_to[0] = 8; m_to[1] = 16; m_to[2] = 0;
        for (int k = 0; k < N; k++) begin
            m_mode[k] = 0; m_word[k] = 1'b0; m_n[k] = 0; m_gap[k] = 0; m_err[k] = 1'b0;
        end
        rstn = 1'b0; req = 1'b0; typ = 1'b0; vld = 1'b0; d = 8'h00;

        //   rstn req typ vld d        rdy ack din
        add(0, 0, 0, 0, 8'h00,   0, 0, 32'h0);
        add(1, 1, 0, 0, 8'h00,   1, 0, 32'h0);
        add(1, 1, 0, 1, 8'hA5,   0, 1, 32'h000000A5);
        add(1, 1, 0, 1, 8'hFF,   0, 1, 32'h000000A5);
        add(1, 0, 0, 1, 8'hFF,   0, 0, 32'h000000A5);
        add(1, 1, 1, 1, 8'h78,   1, 0, 32'h0);
        add(1, 1, 1, 1, 8'h78,   1, 0, 32'h00000078);
        add(1, 1, 1, 1, 8'h56,   1, 0, 32'h00005678);
        add(1, 1, 1, 1, 8'h34,   1, 0, 32'h00345678);
        add(1, 1, 1, 1, 8'h12,   0, 1, 32'h12345678);
        add(1, 0, 0, 0, 8'h00,   0, 0, 32'h12345678);
        add(1, 1, 1, 0, 8'h00,   1, 0, 32'h0);
        add(1, 1, 1, 1, 8'hEF,   1, 0, 32'h000000EF);
        add(1, 1, 1, 1, 8'hBE,   1, 0, 32'h0000BEEF);
        add(1, 0, 1, 1, 8'hAD,   0, 0, 32'h0000BEEF);
        add(1, 0, 0, 0, 8'h00,   0, 0, 32'h0000BEEF);
        add(1, 1, 1, 0, 8'h00,   1, 0, 32'h0);
        add(1, 1, 1, 1, 8'h11,   1, 0, 32'h00000011);
        add(1, 1, 1, 1, 8'h22,   1, 0, 32'h00002211);
        add(1, 1, 1, 1, 8'h33,   1, 0, 32'h00332211);
        add(0, 1, 1, 1, 8'h44,   0, 0, 32'h0);
        add(1, 0, 0, 0, 8'h00,   0, 0, 32'h0);
        add(1, 1, 1, 0, 8'h00,   1, 0, 32'h0);
        add(1, 1, 1, 1, 8'hEF,   1, 0, 32'h000000EF);
        add(1, 1, 1, 1, 8'hBE,   1, 0, 32'h0000BEEF);
        add(1, 1, 1, 1, 8'hAD,   1, 0, 32'h00ADBEEF);
        add(1, 1, 1, 1, 8'hDE,   0, 1, 32'hDEADBEEF);
        add(1, 0, 0, 0, 8'h00,   0, 0, 32'hDEADBEEF);

        foreach (tbl[i]) begin
            cyc(tbl[i].rstn, tbl[i].req, tbl[i].typ, tbl[i].vld, tbl[i].d);
            for (int k = 0; k < N; k++)
                check($sformatf("tbl%0d", i), k, obs(k), ex(tbl[i].e_rdy, tbl[i].e_ack, 1'b0, tbl[i].e_din));
        end

        // Timeout: two bytes, eight silent cycles, then a fresh word.
        cyc(0, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h01);
        cyc(1, 1, 1, 1, 8'h02);
        for (int s = 1; s <= 8; s++) begin
            cyc(1, 1, 1, 0, 8'h00);
            check($sformatf("to_gap%0d", s), 0, obs(0),
                  ex(1'b1, 1'b0, s == 8, (s == 8) ? 32'h0 : 32'h00000201));
            check($sformatf("to_gap%0d", s), 1, obs(1), ex(1'b1, 1'b0, 1'b0, 32'h00000201));
            check($sformatf("to_gap%0d", s), 2, obs(2), ex(1'b1, 1'b0, 1'b0, 32'h00000201));
        end
        wb[0] = 8'hEF; wb[1] = 8'hBE; wb[2] = 8'hAD; wb[3] = 8'hDE;
        acc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 1, wb[i]);
            acc = acc | (32'(wb[i]) << (8 * i));
            check($sformatf("to_word%0d", i), 0, obs(0), ex(i != 3, i == 3, 1'b0, acc));
            check($sformatf("to_word%0d", i), 1, obs(1),
                  ex(i == 0, i != 0, 1'b0, (i == 0) ? 32'h00EF0201 : 32'hBEEF0201));
            check($sformatf("to_word%0d", i), 2, obs(2),
                  ex(i == 0, i != 0, 1'b0, (i == 0) ? 32'h00EF0201 : 32'hBEEF0201));
        end

        // Accept landing on the expiry edge must win with no error.
        cyc(0, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h5A);
        for (int s = 1; s <= 7; s++) cyc(1, 1, 1, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'hC3);
        for (int k = 0; k < N; k++) check("race_acc", k, obs(k), ex(1'b1, 1'b0, 1'b0, 32'h0000C35A));
        cyc(1, 1, 1, 0, 8'h00);
        for (int k = 0; k < N; k++) check("race_after", k, obs(k), ex(1'b1, 1'b0, 1'b0, 32'h0000C35A));

        // Word with idle gaps of 0..5 cycles: no error anywhere.
        cyc(0, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        wb[0] = 8'h78; wb[1] = 8'h56; wb[2] = 8'h34; wb[3] = 8'h12;
        gaps[0] = 2; gaps[1] = 5; gaps[2] = 0; gaps[3] = 3;
        acc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                cyc(1, 1, 1, 0, 8'h00);
                for (int k = 0; k < N; k++)
                    check($sformatf("gap_b%0d_g%0d", i, g), k, obs(k), ex(1'b1, 1'b0, 1'b0, acc));
            end
            cyc(1, 1, 1, 1, wb[i]);
            acc = acc | (32'(wb[i]) << (8 * i));
            for (int k = 0; k < N; k++)
                check($sformatf("gap_b%0d", i), k, obs(k), ex(i != 3, i == 3, 1'b0, acc));
        end

        // Random traffic against the model.
        cyc(0, 0, 0, 0, 8'h00);
        win = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) win = $urandom_range(0, 2);
            pv = (win == 0) ? 90 : (win == 1) ? 50 : 6;
            if ($urandom_range(0, 7) == 0) req = ~req;
            cyc(($urandom_range(0, 255) != 0), req, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < pv), 8'($urandom));
            for (int k = 0; k < N; k++) check($sformatf("rnd%0d", c), k, obs(k), m_obs(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
